// File: rtl/hashing.sv
// Ascon-style sponge hash with a bit-serial message input and digest output.
// One permutation round is evaluated per clock. Once the digest is complete it
// is replayed LSB-first on hash_digestxSO for as long as hash_readyxSO is high.
module hashing #(
   parameter int r = 64,
   parameter int a = 12,
   parameter int b = 12,
   parameter int h = 256,
   parameter int l = 256,
   parameter int y = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic messagexSI,
   input  logic startxSI,
   output logic hash_digestxSO,
   output logic hash_readyxSO
);

   // Sponge geometry: S padded blocks of r bits, L squeezed chunks of r bits
   localparam int S  = y / r + 1;
   localparam int PW = S * r;
   localparam int L  = l / r;
   localparam int DW = l;
   localparam int BW = $clog2(S) + 1;
   localparam int CW = $clog2(L) + 1;
   localparam int KW = (l > 1) ? $clog2(l) : 1;

   localparam logic [63:0]    IV         = {8'h00, 8'(r), 8'(a), 8'(a - b), 32'(h)};
   localparam logic [3:0]     JA         = 4'(12 - a);
   localparam logic [3:0]     JB         = 4'(12 - b);
   localparam logic [BW-1:0]  LAST_BLK   = BW'(S - 1);
   localparam logic [CW-1:0]  LAST_CHUNK = CW'(L - 1);
   localparam logic [KW-1:0]  LAST_K     = KW'(l - 1);

   typedef enum logic [2:0] {IDLE, INIT, ABSORB, SQUEEZE, DONE} state_t;

   function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
      return (v >> n) | (v << (64 - n));
   endfunction

   // One full round: constant addition, bit-sliced S-box, linear diffusion
   function automatic logic [4:0][63:0] asconRound(input logic [4:0][63:0] s,
                                                   input logic [3:0] j);
      logic [63:0] x0, x1, x2, x3, x4;
      logic [63:0] t0, t1, t2, t3, t4;
      x0 = s[0];
      x1 = s[1];
      x2 = s[2] ^ {56'd0, 4'(4'd15 - j), j};
      x3 = s[3];
      x4 = s[4];
      x0 = x0 ^ x4;
      x4 = x4 ^ x3;
      x2 = x2 ^ x1;
      t0 = ~x0 & x1;
      t1 = ~x1 & x2;
      t2 = ~x2 & x3;
      t3 = ~x3 & x4;
      t4 = ~x4 & x0;
      x0 = x0 ^ t1;
      x1 = x1 ^ t2;
      x2 = x2 ^ t3;
      x3 = x3 ^ t4;
      x4 = x4 ^ t0;
      x1 = x1 ^ x0;
      x0 = x0 ^ x4;
      x3 = x3 ^ x2;
      x2 = ~x2;
      x0 = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
      x1 = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
      x2 = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
      x3 = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
      x4 = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);
      return {x4, x3, x2, x1, x0};
   endfunction

   state_t              r_fsm;
   logic [4:0][63:0]    r_x;
   logic [y-1:0]        r_msg;
   logic [3:0]          r_round;
   logic [BW-1:0]       r_blk;
   logic [CW-1:0]       r_chunk;
   logic [l-1:0]        r_digest;
   logic [KW-1:0]       r_k;
   logic                r_ready;
   logic                r_bit;

   logic [4:0][63:0]    w_round;
   logic [PW-1:0]       w_padded;
   logic [BW-1:0]       w_xorIdx;
   logic [r-1:0]        w_block;
   logic [63:0]         w_lane;
   logic                w_permEnd;
   logic                w_sqCapture;
   logic [KW-1:0]       w_kNext;

   assign w_round     = asconRound(r_x, r_round);
   assign w_permEnd   = (r_round == 4'd11);
   assign w_padded    = PW'({r_msg, 1'b1}) << (PW - y - 1);
   assign w_xorIdx    = (r_fsm == INIT) ? '0 : r_blk + 1'b1;
   assign w_lane      = 64'(w_block) << (64 - r);
   assign w_sqCapture = (r_round == JB);
   assign w_kNext     = (r_k == LAST_K) ? '0 : r_k + 1'b1;

   // Pick the padded message block that is folded into x0 at the end of the current permutation
   always_comb begin
      w_block = '0;
      for (int i = 0; i < S; i++) begin
         if (w_xorIdx == BW'(i)) begin
            w_block = w_padded[PW - 1 - i * r -: r];
         end
      end
   end

   // Sequencer: every permutation round, block injection, digest capture and serial replay
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fsm    <= IDLE;
         r_x      <= '0;
         r_msg    <= '0;
         r_round  <= '0;
         r_blk    <= '0;
         r_chunk  <= '0;
         r_digest <= '0;
         r_k      <= '0;
         r_ready  <= 1'b0;
         r_bit    <= 1'b0;
      end else begin
         case (r_fsm)
            IDLE: begin
               r_msg <= (r_msg << 1) | y'(messagexSI);
               if (startxSI) begin
                  r_x     <= {256'd0, IV};
                  r_round <= JA;
                  r_blk   <= '0;
                  r_fsm   <= INIT;
               end
            end
            INIT: begin
               r_x <= w_round;
               if (w_permEnd) begin
                  r_x[0]  <= w_round[0] ^ w_lane;
                  r_blk   <= '0;
                  r_round <= (S == 1) ? JA : JB;
                  r_fsm   <= ABSORB;
               end else begin
                  r_round <= r_round + 4'd1;
               end
            end
            ABSORB: begin
               r_x <= w_round;
               if (w_permEnd) begin
                  if (r_blk == LAST_BLK) begin
                     r_round <= JB;
                     r_chunk <= '0;
                     r_fsm   <= SQUEEZE;
                  end else begin
                     r_x[0]  <= w_round[0] ^ w_lane;
                     r_blk   <= r_blk + 1'b1;
                     r_round <= ((r_blk + 1'b1) == LAST_BLK) ? JA : JB;
                  end
               end else begin
                  r_round <= r_round + 4'd1;
               end
            end
            SQUEEZE: begin
               if (w_sqCapture) begin
                  r_digest <= (r_digest << r) | DW'(r_x[0][63 -: r]);
                  r_chunk  <= r_chunk + 1'b1;
               end
               if (w_sqCapture && (r_chunk == LAST_CHUNK)) begin
                  r_fsm <= DONE;
               end else begin
                  r_x     <= w_round;
                  r_round <= w_permEnd ? JB : r_round + 4'd1;
               end
            end
            DONE: begin
               if (!r_ready) begin
                  r_ready <= 1'b1;
                  r_k     <= '0;
                  r_bit   <= r_digest[0];
               end else begin
                  r_k   <= w_kNext;
                  r_bit <= r_digest[w_kNext];
               end
            end
            default: begin
               r_fsm <= IDLE;
            end
         endcase
      end
   end

   assign hash_readyxSO  = r_ready;
   assign hash_digestxSO = r_bit;

endmodule

// File: tb/tb_hashing.sv
// Directed bench for hashing. A behavioural Ascon-Hash model (table S-box)
// produces the expected digest and latency for each run; they are queued when
// the start request is driven and compared when the digest appears.
module tb_hashing;

   localparam int A          = 12;
   localparam int B          = 12;
   localparam int R          = 64;
   localparam int LEN        = 256;
   localparam int WAIT_LIMIT = 400;
   localparam logic [63:0] MODEL_IV = 64'h00400c0000000100;

   typedef struct {
      int           latency;
      logic [255:0] digest;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [1:0]  msgIn;
   logic [1:0]  startIn;
   logic [1:0]  digOut;
   logic [1:0]  readyOut;
   int          checks;
   int          errors;
   exp_t        sbQ [$];
   logic [4:0]  sboxTable [32];

   hashing #(.r(64), .a(12), .b(12), .h(256), .l(256), .y(64)) dut (
      .clk            (clk),
      .rst            (rst),
      .messagexSI     (msgIn[0]),
      .startxSI       (startIn[0]),
      .hash_digestxSO (digOut[0]),
      .hash_readyxSO  (readyOut[0])
   );

   hashing #(.r(64), .a(12), .b(12), .h(256), .l(256), .y(128)) dut2 (
      .clk            (clk),
      .rst            (rst),
      .messagexSI     (msgIn[1]),
      .startxSI       (startIn[1]),
      .hash_digestxSO (digOut[1]),
      .hash_readyxSO  (readyOut[1])
   );

   // Free-running clock, period 10
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something never returns
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [63:0] modelRor(input logic [63:0] v, input int n);
      return (v >> n) | (v << (64 - n));
   endfunction

   function automatic logic [4:0][63:0] modelPerm(input logic [4:0][63:0] st, input int n);
      logic [4:0][63:0] s;
      logic [4:0] col;
      logic [4:0] o;
      s = st;
      for (int j = 12 - n; j < 12; j++) begin
         s[2] = s[2] ^ 64'(((15 - j) << 4) | j);
         for (int p = 0; p < 64; p++) begin
            col = {s[0][p], s[1][p], s[2][p], s[3][p], s[4][p]};
            o = sboxTable[col];
            s[0][p] = o[4];
            s[1][p] = o[3];
            s[2][p] = o[2];
            s[3][p] = o[1];
            s[4][p] = o[0];
         end
         s[0] = s[0] ^ modelRor(s[0], 19) ^ modelRor(s[0], 28);
         s[1] = s[1] ^ modelRor(s[1], 61) ^ modelRor(s[1], 39);
         s[2] = s[2] ^ modelRor(s[2], 1)  ^ modelRor(s[2], 6);
         s[3] = s[3] ^ modelRor(s[3], 10) ^ modelRor(s[3], 17);
         s[4] = s[4] ^ modelRor(s[4], 7)  ^ modelRor(s[4], 41);
      end
      return s;
   endfunction

   function automatic logic [255:0] modelHash(input logic [127:0] msg, input int ylen);
      logic [255:0]     padded;
      logic [63:0]      blk;
      logic [4:0][63:0] s;
      logic [255:0]     d;
      int               nb;
      nb = ylen / R + 1;
      padded = '0;
      for (int t = 0; t < ylen; t++) padded[nb * 64 - 1 - t] = msg[ylen - 1 - t];
      padded[nb * 64 - 1 - ylen] = 1'b1;
      s = '0;
      s[0] = MODEL_IV;
      s = modelPerm(s, A);
      for (int i = 0; i < nb; i++) begin
         for (int bb = 0; bb < 64; bb++) blk[63 - bb] = padded[nb * 64 - 1 - 64 * i - bb];
         s[0] = s[0] ^ blk;
         s = modelPerm(s, (i == nb - 1) ? A : B);
      end
      d = '0;
      for (int c = 0; c < LEN / R; c++) begin
         d = {d[191:0], s[0]};
         if (c < LEN / R - 1) s = modelPerm(s, B);
      end
      return d;
   endfunction

   function automatic int modelLatency(input int ylen);
      int nb;
      nb = ylen / R + 1;
      return 2 * A + (nb - 1) * B + (LEN / R - 1) * B + 2;
   endfunction

   task automatic expectEq(input string tag, input logic [255:0] got, input logic [255:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
      end
   endtask

   task automatic applyReset();
      startIn = '0;
      msgIn   = '0;
      rst     = 1'b1;
      #1;
      expectEq("resetReady0", 256'(readyOut[0]), 256'd0);
      expectEq("resetOut0",   256'(digOut[0]),   256'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic shiftMessage(input int sel, input logic [127:0] msg, input int ylen);
      for (int i = 0; i < ylen; i++) begin
         msgIn[sel]   = msg[ylen - 1 - i];
         startIn[sel] = (i == ylen - 1);
         @(posedge clk);
         #1;
      end
   endtask

   // mode 0: start held for 'hold' sampled edges; mode 1: start toggles every cycle
   task automatic applyStimulus(input int sel, input logic [127:0] msg, input int ylen,
                                input int mode, input int hold, output int lat);
      exp_t e;
      bit   seen;
      shiftMessage(sel, msg, ylen);
      e.latency = modelLatency(ylen);
      e.digest  = modelHash(msg, ylen);
      sbQ.push_back(e);
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < WAIT_LIMIT) begin
         startIn[sel] = (mode == 0) ? (lat + 1 < hold) : (lat % 2 == 0);
         msgIn[sel]   = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
         lat++;
         if (readyOut[sel]) seen = 1'b1;
         else expectEq("preReadyOut", 256'(digOut[sel]), 256'd0);
      end
      startIn[sel] = 1'b0;
      msgIn[sel]   = 1'b0;
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL readyTimeout observed=%0d expected=%0d", lat, e.latency);
         lat = -1;
      end
   endtask

   task automatic checkOutput(input int sel, input int lat, input int periods);
      exp_t         e;
      logic [255:0] got;
      logic         held;
      if (sbQ.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboardEmpty observed=0 expected=1");
         return;
      end
      e = sbQ.pop_front();
      expectEq("latency", 256'(lat), 256'(e.latency));
      held = 1'b1;
      for (int p = 0; p < periods; p++) begin
         for (int k = 0; k < LEN; k++) begin
            got[k] = digOut[sel];
            if (readyOut[sel] !== 1'b1) held = 1'b0;
            @(posedge clk);
            #1;
         end
         expectEq("digestPeriod", got, e.digest);
      end
      expectEq("readyHeld", 256'(held), 256'd1);
   endtask

   // Directed sequence of all scenarios
   initial begin
      int  lat;
      logic stuck;
      sboxTable = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
      checks  = 0;
      errors  = 0;
      rst     = 1'b1;
      startIn = '0;
      msgIn   = '0;
      #1;
      expectEq("initReady0", 256'(readyOut[0]), 256'd0);
      expectEq("initOut0",   256'(digOut[0]),   256'd0);
      expectEq("initReady1", 256'(readyOut[1]), 256'd0);
      expectEq("initOut1",   256'(digOut[1]),   256'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      $display("[TB] scenario 1/5: start held 3 cycles, two digest periods");
      applyStimulus(0, 128'h0001020304050607, 64, 0, 3, lat);
      checkOutput(0, lat, 2);

      $display("[TB] reset while digest is streaming");
      #2;
      rst = 1'b1;
      #1;
      expectEq("midOutReady", 256'(readyOut[0]), 256'd0);
      expectEq("midOutBit",   256'(digOut[0]),   256'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      $display("[TB] scenario 2: start held 20 cycles");
      applyStimulus(0, 128'h0001020304050607, 64, 0, 20, lat);
      checkOutput(0, lat, 1);
      applyReset();

      $display("[TB] scenario 6: start toggling while busy");
      applyStimulus(0, 128'h0001020304050607, 64, 1, 0, lat);
      checkOutput(0, lat, 1);
      applyReset();

      $display("[TB] scenario 4: reset during INIT");
      shiftMessage(0, 128'h0001020304050607, 64);
      startIn[0] = 1'b0;
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      #2;
      rst = 1'b1;
      #1;
      expectEq("abortReady", 256'(readyOut[0]), 256'd0);
      expectEq("abortOut",   256'(digOut[0]),   256'd0);
      @(posedge clk);
      #1;
      rst   = 1'b0;
      stuck = 1'b0;
      repeat (modelLatency(64) + 10) begin
         @(posedge clk);
         #1;
         if (readyOut[0] !== 1'b0) stuck = 1'b1;
      end
      expectEq("abortNoRestart", 256'(stuck), 256'd0);
      applyStimulus(0, 128'h0001020304050607, 64, 0, 3, lat);
      checkOutput(0, lat, 1);
      applyReset();

      $display("[TB] scenario 3: 128-bit message");
      applyStimulus(1, 128'h000102030405060708090a0b0c0d0e0f, 128, 0, 3, lat);
      checkOutput(1, lat, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
